// File: rtl/pf_pll_pkg.sv
// Shared encodings and field widths for the PLL DRI access controller.
package pf_pll_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 33;
  localparam int OP_W   = 2;
  localparam int CTRL_W = OP_W + ADDR_W;
  localparam int TMO_W  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } dri_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_CAPTURE,
    ST_WAIT_UNLOCK,
    ST_WAIT_LOCK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic              relock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_req_t;

  // Saturating increment so a long wait never wraps back into range.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_W'(1);
  endfunction
endpackage

// File: rtl/pf_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock input.
module pf_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/pf_pll_dri_ctrl.sv
// PLL DRI access controller: one read/write per request, DRI clock at i_clk/2,
// optional wait for the PLL to drop and regain lock after a write.
module pf_pll_dri_ctrl
  import pf_pll_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int ARST_CYCLES  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_relock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_locked,
  output logic              o_dri_clk,
  output logic [CTRL_W-1:0] o_dri_ctrl,
  output logic [DATA_W-1:0] o_dri_wdata,
  output logic              o_dri_arst_n,
  input  logic [DATA_W-1:0] i_dri_rdata,
  input  logic              i_dri_interrupt,
  input  logic              i_pll_lock
);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] ARST_LAST = TMO_W'(ARST_CYCLES - 1);

  state_e            state_q;
  acc_req_t          req_q;
  logic              busy_q, ack_q, err_q, err_flag_q, ph_q, dri_clk_q, arst_n_q;
  logic [DATA_W-1:0] rdata_q, dri_wdata_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [TMO_W-1:0]  tmo_q, tmo_d, arst_cnt_q;
  logic              locked;
  logic              irq_win;
  dri_op_e           op_d;

  pf_sync2 u_lock_sync (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_pll_lock),
    .q_o   (locked)
  );

  assign tmo_d   = sat_inc(tmo_q);
  assign op_d    = req_q.we ? OP_WRITE : OP_READ;
  assign irq_win = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_CAPTURE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      ph_q        <= 1'b0;
      dri_clk_q   <= 1'b0;
      arst_n_q    <= 1'b0;
      arst_cnt_q  <= '0;
      rdata_q     <= '0;
      dri_wdata_q <= '0;
      ctrl_q      <= '0;
      tmo_q       <= '0;
    end else begin
      if (!arst_n_q) begin
        if (arst_cnt_q == ARST_LAST) arst_n_q <= 1'b1;
        else                         arst_cnt_q <= arst_cnt_q + TMO_W'(1);
      end
      dri_clk_q <= arst_n_q ? ~dri_clk_q : 1'b0;
      ack_q     <= 1'b0;
      if (irq_win && i_dri_interrupt) err_flag_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (i_req && arst_n_q) begin
            req_q      <= '{we: i_we, relock: i_relock, addr: i_addr, wdata: i_wdata};
            busy_q     <= 1'b1;
            err_flag_q <= 1'b0;
            state_q    <= ST_SETUP;
          end
        end
        // Launch only from a low DRI clock phase so the strobe spans one full period.
        ST_SETUP: begin
          if (!dri_clk_q) begin
            ctrl_q      <= {op_d, req_q.addr};
            dri_wdata_q <= req_q.wdata;
            ph_q        <= 1'b0;
            state_q     <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          ph_q <= ~ph_q;
          if (ph_q) begin
            ctrl_q[CTRL_W-1 -: OP_W] <= OP_IDLE;
            state_q                  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          ph_q <= ~ph_q;
          if (ph_q) begin
            if (!req_q.we) rdata_q <= i_dri_rdata;
            tmo_q   <= '0;
            state_q <= (req_q.we && req_q.relock) ? ST_WAIT_UNLOCK : ST_DONE;
          end
        end
        ST_WAIT_UNLOCK: begin
          if (!locked) begin
            tmo_q   <= '0;
            state_q <= ST_WAIT_LOCK;
          end else if (tmo_q >= TMO_LAST) begin
            err_flag_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked) begin
            state_q <= ST_DONE;
          end else if (tmo_q >= TMO_LAST) begin
            err_flag_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b1;
          err_q   <= err_flag_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_err        = err_q;
  assign o_locked     = locked;
  assign o_dri_clk    = dri_clk_q;
  assign o_dri_ctrl   = ctrl_q;
  assign o_dri_wdata  = dri_wdata_q;
  assign o_dri_arst_n = arst_n_q;
endmodule

// File: tb/tb_pf_pll_dri_ctrl.sv
// Directed bench: default-timeout instance A plus a LOCK_TIMEOUT=20 instance B.
module tb_pf_pll_dri_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_a, req_b, we, relock, dri_int, pll_lock;
  logic [8:0]  addr;
  logic [32:0] wdata, dri_rdata;

  logic        a_busy, a_ack, a_err, a_locked, a_dclk, a_arst_n;
  logic [32:0] a_rdata, a_dwdata;
  logic [10:0] a_ctrl;
  logic        b_busy, b_ack, b_err, b_locked, b_dclk, b_arst_n;
  logic [32:0] b_rdata, b_dwdata;
  logic [10:0] b_ctrl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pf_pll_dri_ctrl u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_we(we), .i_relock(relock),
    .i_addr(addr), .i_wdata(wdata), .o_busy(a_busy), .o_ack(a_ack),
    .o_rdata(a_rdata), .o_err(a_err), .o_locked(a_locked), .o_dri_clk(a_dclk),
    .o_dri_ctrl(a_ctrl), .o_dri_wdata(a_dwdata), .o_dri_arst_n(a_arst_n),
    .i_dri_rdata(dri_rdata), .i_dri_interrupt(dri_int), .i_pll_lock(pll_lock)
  );

  pf_pll_dri_ctrl #(.LOCK_TIMEOUT(20)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_we(we), .i_relock(relock),
    .i_addr(addr), .i_wdata(wdata), .o_busy(b_busy), .o_ack(b_ack),
    .o_rdata(b_rdata), .o_err(b_err), .o_locked(b_locked), .o_dri_clk(b_dclk),
    .o_dri_ctrl(b_ctrl), .o_dri_wdata(b_dwdata), .o_dri_arst_n(b_arst_n),
    .i_dri_rdata(dri_rdata), .i_dri_interrupt(dri_int), .i_pll_lock(pll_lock)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".busy"},   a_busy,   0);
    chk({tag, ".ack"},    a_ack,    0);
    chk({tag, ".err"},    a_err,    0);
    chk({tag, ".rdata"},  a_rdata,  0);
    chk({tag, ".ctrl"},   a_ctrl,   0);
    chk({tag, ".dwdata"}, a_dwdata, 0);
    chk({tag, ".dclk"},   a_dclk,   0);
    chk({tag, ".arst_n"}, a_arst_n, 0);
    chk({tag, ".locked"}, a_locked, 0);
  endtask

  // Present a request for one cycle; returns at the sample point after the accepting edge.
  task automatic issue(input bit to_b, input logic w, input logic rl,
                       input logic [8:0] a, input logic [32:0] d);
    we = w; relock = rl; addr = a; wdata = d;
    if (to_b) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [8:0] a, input logic [32:0] model,
                        input bit irq, input logic exp_err);
    int lat = -1;
    int ctrl_hits = 0;
    bit pulsed = 0;
    dri_rdata = model;
    issue(0, 1'b0, 1'b0, a, 33'h0);
    for (int i = 0; i <= 30; i++) begin
      if (a_ctrl === {2'b01, a}) ctrl_hits++;
      if (irq && !pulsed && a_ctrl[10:9] === 2'b01) begin dri_int = 1'b1; pulsed = 1; end
      else dri_int = 1'b0;
      if (a_ack) begin lat = i; break; end
      @(negedge clk);
    end
    dri_int = 1'b0;
    chk({tag, ".latency"}, (lat == 6 || lat == 7), 1);
    chk({tag, ".strobe"}, ctrl_hits, 2);
    chk({tag, ".rdata"}, a_rdata, model);
    chk({tag, ".err"}, a_err, exp_err);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int hits;
    bit seen;
    rst = 1'b1; req_a = 0; req_b = 0; we = 0; relock = 0; addr = '0; wdata = '0;
    dri_rdata = '0; dri_int = 0; pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");

    // Release; a request while the DRI reset is still low must be ignored.
    rst = 1'b0;
    @(negedge clk);
    chk("arst.c1", a_arst_n, 0);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    chk("arst.c2", a_arst_n, 0);
    chk("early_req.busy", a_busy, 0);
    chk("locked.sync", a_locked, 1);
    @(negedge clk);
    chk("arst.c3", a_arst_n, 0);
    @(negedge clk);
    chk("arst.c4", a_arst_n, 1);
    repeat (2) @(negedge clk);

    // Basic read, with a second request presented while busy.
    dri_rdata = 33'h1_2345_6789;
    issue(0, 1'b0, 1'b0, 9'h012, 33'h0);
    lat = -1; hits = 0;
    for (int i = 0; i <= 30; i++) begin
      if (i == 0) chk("rd1.busy", a_busy, 1);
      if (a_ctrl === 11'h212) hits++;
      if (i == 2) begin req_a = 1'b1; addr = 9'h0AA; end
      if (i == 3) req_a = 1'b0;
      if (a_ack) begin lat = i; break; end
      @(negedge clk);
    end
    chk("rd1.latency", (lat == 6 || lat == 7), 1);
    chk("rd1.strobe", hits, 2);
    chk("rd1.rdata", a_rdata, 33'h1_2345_6789);
    chk("rd1.err", a_err, 0);
    @(negedge clk);
    chk("rd1.ack_pulse", a_ack, 0);
    chk("rd1.op_idle", a_ctrl[10:9], 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_busy || a_ctrl[10:9] != 2'b00) seen = 1;
      @(negedge clk);
    end
    chk("busy_req_ignored", seen, 0);

    // Write with relock: lock drops 10 cycles after accept, returns 100 later.
    issue(0, 1'b1, 1'b1, 9'h005, 33'h0_0000_0027);
    lat = -1; hits = 0;
    for (int i = 0; i <= 300; i++) begin
      if (a_ctrl === 11'h405) hits++;
      if (i == 10) pll_lock = 1'b0;
      if (i == 110) pll_lock = 1'b1;
      if (a_ack) begin lat = i; break; end
      @(negedge clk);
    end
    chk("wr.strobe", hits, 2);
    chk("wr.latency", lat, 114);
    chk("wr.err", a_err, 0);
    chk("wr.dwdata_held", a_dwdata, 33'h27);
    chk("wr.rdata_held", a_rdata, 33'h1_2345_6789);
    @(negedge clk);

    // Relock timeout on the LOCK_TIMEOUT=20 instance; lock never drops.
    issue(1, 1'b1, 1'b1, 9'h005, 33'h0_0000_0027);
    lat = -1;
    for (int i = 0; i <= 100; i++) begin
      if (b_ack) begin lat = i; break; end
      @(negedge clk);
    end
    chk("tmo.latency", (lat == 26 || lat == 27), 1);
    chk("tmo.err", b_err, 1);
    @(negedge clk);

    // Interrupt during strobe, then a clean read must clear the error.
    read_a("irq", 9'h033, 33'h0_DEAD_BEEF, 1, 1'b1);
    read_a("clean", 9'h012, 33'h1_2345_6789, 0, 1'b0);

    // Reset while waiting for lock to return.
    issue(0, 1'b1, 1'b1, 9'h005, 33'h0_0000_0027);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) pll_lock = 1'b0;
      if (a_ack) seen = 1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    pll_lock = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (a_ack) seen = 1;
      chk($sformatf("midrst.arst%0d", k), a_arst_n, (k == 4));
    end
    chk("midrst.no_ack", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pf_pll_dri_ctrl.md
PF_PLL_DRI_CTRL -- requirements
Module: pf_pll_dri_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535: max i_clk cycles spent in each relock wait phase; range 1..65535.
REQ-002 Parameter ARST_CYCLES, default 4: i_clk cycles o_dri_arst_n stays low after reset release.
REQ-003 i_clk  in  1  single clock; all logic rising-edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  access request; accepted only when o_busy=0.
REQ-006 i_we  in  1  1=write, 0=read; sampled with i_req.
REQ-007 i_relock  in  1  write only: wait for PLL lock drop/regain after access.
REQ-008 i_addr  in  9  DRI register address.
REQ-009 i_wdata  in  33  write data.
REQ-010 o_busy  out  1  access in progress.
REQ-011 o_ack  out  1  one-cycle completion pulse.
REQ-012 o_rdata  out  33  read data, valid from o_ack, held until next accepted read.
REQ-013 o_err  out  1  valid with o_ack: interrupt seen or relock timeout.
REQ-014 o_locked  out  1  synchronized PLL lock.
REQ-015 o_dri_clk  out  1  DRI clock, i_clk/2.
REQ-016 o_dri_ctrl  out  11  [10:9] op (00 idle, 01 read, 10 write), [8:0] address.
REQ-017 o_dri_wdata  out  33  DRI write data.
REQ-018 o_dri_arst_n  out  1  DRI reset, active-low.
REQ-019 i_dri_rdata  in  33  DRI read data.
REQ-020 i_dri_interrupt  in  1  DRI interrupt.
REQ-021 i_pll_lock  in  1  PLL lock, asynchronous.

Function
REQ-022 o_dri_clk SHALL toggle every i_clk cycle while o_dri_arst_n=1, and be held 0 otherwise.
REQ-023 States SHALL be IDLE, SETUP, STROBE, CAPTURE, WAIT_UNLOCK, WAIT_LOCK, DONE.
REQ-024 IDLE: i_req=1 and o_dri_arst_n=1 -> latch we/relock/addr/wdata, o_busy=1, go SETUP; i_req ignored while o_busy=1.
REQ-025 SETUP: wait for an i_clk cycle in which o_dri_clk is 0, then drive o_dri_ctrl={op,addr}, o_dri_wdata=wdata, go STROBE.
REQ-026 STROBE: hold ctrl/wdata for exactly 2 i_clk cycles (one full DRI clock), then op=00, go CAPTURE; o_dri_wdata holds its last value.
REQ-027 CAPTURE: after 2 more i_clk cycles, a read SHALL register i_dri_rdata into o_rdata; next state WAIT_UNLOCK if write with relock=1, else DONE.
REQ-028 WAIT_UNLOCK: go WAIT_LOCK when o_locked=0; after LOCK_TIMEOUT cycles without it, set error flag and go DONE.
REQ-029 WAIT_LOCK: go DONE when o_locked=1; timeout as REQ-028 with counter reloaded on entry.
REQ-030 DONE: o_ack=1 for one cycle, o_err=error flag, o_busy=0 next cycle, go IDLE; error flag cleared on acceptance.
REQ-031 Error flag SHALL also set if i_dri_interrupt=1 in any cycle from SETUP through CAPTURE.
REQ-032 Non-relock access latency, i_req accept to o_ack: 6 or 7 i_clk cycles depending on DRI clock phase.
REQ-033 o_locked = i_pll_lock through a 2-flop synchronizer (2-cycle latency).
REQ-034 Timeout counter 16-bit, saturating, never wraps.

Reset
REQ-035 During i_rst: state IDLE, o_busy=0, o_ack=0, o_err=0, o_rdata=0, o_dri_ctrl=0, o_dri_wdata=0, o_dri_clk=0, o_dri_arst_n=0, o_locked=0, synchronizer flops 0.
REQ-036 o_dri_arst_n SHALL rise ARST_CYCLES cycles after i_rst falls; requests before then are ignored.
REQ-037 i_rst mid-access SHALL abort without o_ack and apply REQ-035 next cycle.

Structure
REQ-038 State encoding, op codes (IDLE/READ/WRITE) and DRI field widths SHALL live in shared package pf_pll_pkg.
REQ-039 Lock synchronizer SHALL be sub-module pf_sync2 (2-flop, reset to 0).

Verification
REQ-040 Read addr 0x012, model rdata=0x1_2345_6789 -> ctrl=0x212 for 2 cycles, o_ack within 7 cycles, o_rdata=0x1_2345_6789, o_err=0.
REQ-041 Write addr 0x005, wdata=0x0_0000_0027, relock=1, lock drops 10 cycles later and returns 100 cycles later -> ctrl=0x405, o_ack after relock, o_err=0.
REQ-042 LOCK_TIMEOUT=20, write relock=1, lock never drops -> o_ack with o_err=1 ~20 cycles after CAPTURE.
REQ-043 i_dri_interrupt pulsed during STROBE on a read -> o_ack with o_err=1; next clean read o_err=0.
REQ-044 Second i_req during busy -> ignored; i_rst during WAIT_LOCK -> no o_ack, all outputs at reset values, o_dri_arst_n low 4 cycles after release.
